// File: rtl/proc_sequencer_pkg.sv
// Shared widths, state encoding and the command-length legality rule for proc_sequencer.
package proc_sequencer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int OP_WIDTH   = 3;
  localparam int LEN_WIDTH  = 11;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1 << ADDR_WIDTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_OP,
    S_RUN,
    S_DRAIN,
    S_R_ISSUE,
    S_R_WAIT,
    S_R_CAP,
    S_R_OUT
  } seq_state_t;

  function automatic logic len_legal(input logic [LEN_WIDTH-1:0] len);
    return (len != '0) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/proc_sequencer_seq_watchdog.sv
// Cycle watchdog for the RUN phase: counts enabled cycles, flags the last one before TIMEOUT.
module seq_watchdog #(
  parameter int TIMEOUT = 2047
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Asserted during the TIMEOUT-th enabled cycle so the registered reaction lands exactly TIMEOUT cycles in.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Host-side sequencer for top_processor: load A/B/op BRAMs, run, wait for done, stream results out.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 2047
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] proc_data_o,
  output logic [ADDR_WIDTH-1:0] proc_addr_data_o,
  output logic                  proc_ena_a_o,
  output logic                  proc_wea_a_o,
  output logic                  proc_ena_b_o,
  output logic                  proc_wea_b_o,
  output logic                  proc_ena_res_o,
  output logic                  proc_wea_res_o,
  output logic [OP_WIDTH-1:0]   proc_op_o,
  output logic [ADDR_WIDTH-1:0] proc_addr_op_o,
  output logic                  proc_ena_op_o,
  output logic                  proc_wea_op_o,
  output logic                  proc_start_o,
  input  logic                  proc_done_i,
  input  logic [DATA_WIDTH-1:0] proc_result_i
);

  seq_state_t state, state_nxt;
  logic [LEN_WIDTH-1:0]  k, k_nxt, len_q, len_nxt;
  logic [DATA_WIDTH-1:0] data_nxt, m_data_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt, addr_op_nxt;
  logic [OP_WIDTH-1:0]   op_nxt;
  logic ena_a_nxt, ena_b_nxt, ena_op_nxt, ena_res_nxt, start_nxt, err_nxt, m_valid_nxt;
  logic s_hs, last_k, wd_clear, wd_enable, wd_expired;

  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign s_ready_o   = ((state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_LOAD_OP)) && (k < len_q);
  assign s_hs        = s_valid_i && s_ready_o;
  assign last_k      = (k == len_q - LEN_WIDTH'(1));
  assign wd_clear    = (state != S_RUN);
  assign wd_enable   = (state == S_RUN);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    len_nxt     = len_q;
    data_nxt    = proc_data_o;
    addr_nxt    = proc_addr_data_o;
    op_nxt      = proc_op_o;
    addr_op_nxt = proc_addr_op_o;
    m_data_nxt  = m_data_o;
    m_valid_nxt = m_valid_o;
    ena_a_nxt   = 1'b0;
    ena_b_nxt   = 1'b0;
    ena_op_nxt  = 1'b0;
    ena_res_nxt = 1'b0;
    start_nxt   = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (len_legal(cmd_len_i)) begin
            len_nxt   = cmd_len_i;
            k_nxt     = '0;
            state_nxt = S_LOAD_A;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_LOAD_A, S_LOAD_B, S_LOAD_OP: begin
        if (s_hs) begin
          data_nxt   = s_data_i;
          addr_nxt   = k[ADDR_WIDTH-1:0];
          ena_a_nxt  = (state == S_LOAD_A);
          ena_b_nxt  = (state == S_LOAD_B);
          ena_op_nxt = (state == S_LOAD_OP);
          if (state == S_LOAD_OP) begin
            op_nxt      = s_data_i[OP_WIDTH-1:0];
            addr_op_nxt = k[ADDR_WIDTH-1:0];
          end
          if (last_k) begin
            k_nxt = '0;
            case (state)
              S_LOAD_A: state_nxt = S_LOAD_B;
              S_LOAD_B: state_nxt = S_LOAD_OP;
              default:  state_nxt = S_RUN;
            endcase
          end else begin
            k_nxt = k + LEN_WIDTH'(1);
          end
        end
      end
      S_RUN: begin
        if (proc_done_i) begin
          state_nxt = S_DRAIN;
        end else if (wd_expired) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!proc_done_i) state_nxt = S_R_ISSUE;
      end
      S_R_ISSUE: state_nxt = S_R_WAIT;
      S_R_WAIT:  state_nxt = S_R_CAP;
      S_R_CAP: begin
        m_data_nxt  = proc_result_i;
        m_valid_nxt = 1'b1;
        state_nxt   = S_R_OUT;
      end
      S_R_OUT: begin
        if (m_ready_i) begin
          m_valid_nxt = 1'b0;
          if (last_k) begin
            k_nxt     = '0;
            state_nxt = S_IDLE;
          end else begin
            k_nxt     = k + LEN_WIDTH'(1);
            state_nxt = S_R_ISSUE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Start and result-read strobes are derived from the state being entered so they are registered yet aligned.
    start_nxt = (state_nxt == S_RUN);
    if (state_nxt == S_R_ISSUE) begin
      ena_res_nxt = 1'b1;
      addr_nxt    = k_nxt[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state            <= S_IDLE;
      k                <= '0;
      len_q            <= '0;
      m_data_o         <= '0;
      m_valid_o        <= 1'b0;
      err_o            <= 1'b0;
      proc_data_o      <= '0;
      proc_addr_data_o <= '0;
      proc_op_o        <= '0;
      proc_addr_op_o   <= '0;
      proc_ena_a_o     <= 1'b0;
      proc_wea_a_o     <= 1'b0;
      proc_ena_b_o     <= 1'b0;
      proc_wea_b_o     <= 1'b0;
      proc_ena_op_o    <= 1'b0;
      proc_wea_op_o    <= 1'b0;
      proc_ena_res_o   <= 1'b0;
      proc_wea_res_o   <= 1'b0;
      proc_start_o     <= 1'b0;
    end else begin
      state            <= state_nxt;
      k                <= k_nxt;
      len_q            <= len_nxt;
      m_data_o         <= m_data_nxt;
      m_valid_o        <= m_valid_nxt;
      err_o            <= err_nxt;
      proc_data_o      <= data_nxt;
      proc_addr_data_o <= addr_nxt;
      proc_op_o        <= op_nxt;
      proc_addr_op_o   <= addr_op_nxt;
      proc_ena_a_o     <= ena_a_nxt;
      proc_wea_a_o     <= ena_a_nxt;
      proc_ena_b_o     <= ena_b_nxt;
      proc_wea_b_o     <= ena_b_nxt;
      proc_ena_op_o    <= ena_op_nxt;
      proc_wea_op_o    <= ena_op_nxt;
      proc_ena_res_o   <= ena_res_nxt;
      proc_wea_res_o   <= 1'b0;
      proc_start_o     <= start_nxt;
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer with a behavioural top_processor (BRAMs + compute + done) model.
module tb_proc_sequencer;
  import proc_sequencer_pkg::*;

  localparam int TIMEOUT = 2047;
  localparam int DEPTH   = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic cmd_valid_i = 1'b0;
  logic [LEN_WIDTH-1:0] cmd_len_i = '0;
  logic [DATA_WIDTH-1:0] s_data_i = '0;
  logic s_valid_i = 1'b0;
  logic m_ready_i;
  logic proc_done_i;
  logic [DATA_WIDTH-1:0] proc_result_i;
  logic cmd_ready_o, s_ready_o, m_valid_o, busy_o, err_o;
  logic [DATA_WIDTH-1:0] m_data_o, proc_data_o;
  logic [ADDR_WIDTH-1:0] proc_addr_data_o, proc_addr_op_o;
  logic proc_ena_a_o, proc_wea_a_o, proc_ena_b_o, proc_wea_b_o, proc_ena_res_o, proc_wea_res_o;
  logic proc_ena_op_o, proc_wea_op_o, proc_start_o;
  logic [OP_WIDTH-1:0] proc_op_o;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  proc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .err_o(err_o),
    .proc_data_o(proc_data_o), .proc_addr_data_o(proc_addr_data_o),
    .proc_ena_a_o(proc_ena_a_o), .proc_wea_a_o(proc_wea_a_o),
    .proc_ena_b_o(proc_ena_b_o), .proc_wea_b_o(proc_wea_b_o),
    .proc_ena_res_o(proc_ena_res_o), .proc_wea_res_o(proc_wea_res_o),
    .proc_op_o(proc_op_o), .proc_addr_op_o(proc_addr_op_o),
    .proc_ena_op_o(proc_ena_op_o), .proc_wea_op_o(proc_wea_op_o),
    .proc_start_o(proc_start_o), .proc_done_i(proc_done_i), .proc_result_i(proc_result_i)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return ~a;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Processor model: BRAMs written by the strobes, registered result read port, done handshake.
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [2:0]  mem_op [DEPTH];
  logic [31:0] mem_res [DEPTH];
  logic [31:0] rd_q = '0;
  bit done_en = 1'b1;

  assign proc_result_i = rd_q;

  always @(posedge CLK) begin
    if (proc_ena_a_o && proc_wea_a_o) mem_a[proc_addr_data_o] <= proc_data_o;
    if (proc_ena_b_o && proc_wea_b_o) mem_b[proc_addr_data_o] <= proc_data_o;
    if (proc_ena_op_o && proc_wea_op_o) mem_op[proc_addr_op_o] <= proc_op_o;
    if (proc_ena_res_o && !proc_wea_res_o) rd_q <= mem_res[proc_addr_data_o];
  end

  initial begin
    proc_done_i = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (RST && proc_start_o && done_en) begin
        repeat ($urandom_range(3, 12)) @(posedge CLK);
        #1;
        for (int i = 0; i < DEPTH; i++) mem_res[i] = alu(mem_a[i], mem_b[i], mem_op[i]);
        proc_done_i = 1'b1;
        for (int t = 0; t < 50 && proc_start_o; t++) begin @(posedge CLK); #1; end
        repeat (2) @(posedge CLK);
        #1;
        proc_done_i = 1'b0;
      end
    end
  end

  int rdy_mode = 0;
  initial begin
    int rcnt = 0;
    m_ready_i = 1'b1;
    forever begin
      @(posedge CLK); #1;
      rcnt++;
      case (rdy_mode)
        0: m_ready_i = 1'b1;
        1: m_ready_i = (rcnt % 3 == 0);
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard and passive monitors, all sampled on the falling edge.
  logic [31:0] sb [$];
  int cyc = 0;
  int wr_idx [3];
  int wr_first [3];
  int wr_last [3];
  int m_count = 0, last_m_hs = 0, busy_fall = 0, start_rise = 0, err_cyc = 0;
  int err_count = 0, strobe_total = 0;
  bit hold_pending = 1'b0, prev_busy = 1'b0, prev_start = 1'b0;
  logic [31:0] held_data = '0;

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      hold_pending = 1'b0;
      prev_busy    = 1'b0;
      prev_start   = 1'b0;
    end else begin
      if (cmd_valid_i && cmd_ready_o && cmd_len_i >= 1 && cmd_len_i <= 1024) begin
        for (int j = 0; j < 3; j++) wr_idx[j] = 0;
        m_count = 0;
      end
      if (proc_ena_a_o || proc_ena_b_o || proc_ena_op_o || proc_wea_res_o) strobe_total++;
      if (proc_ena_a_o && proc_wea_a_o) begin
        checkOutput("addr_a", 64'(proc_addr_data_o), 64'(wr_idx[0]));
        if (wr_idx[0] == 0) wr_first[0] = cyc;
        wr_last[0] = cyc;
        wr_idx[0]++;
      end
      if (proc_ena_b_o && proc_wea_b_o) begin
        checkOutput("addr_b", 64'(proc_addr_data_o), 64'(wr_idx[1]));
        if (wr_idx[1] == 0) wr_first[1] = cyc;
        wr_last[1] = cyc;
        wr_idx[1]++;
      end
      if (proc_ena_op_o && proc_wea_op_o) begin
        checkOutput("addr_op", 64'(proc_addr_op_o), 64'(wr_idx[2]));
        if (wr_idx[2] == 0) wr_first[2] = cyc;
        wr_last[2] = cyc;
        wr_idx[2]++;
      end
      if (hold_pending) begin
        checkOutput("m_hold_valid", 64'(m_valid_o), 64'd1);
        checkOutput("m_hold_data", 64'(m_data_o), 64'(held_data));
      end
      if (m_valid_o && m_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL m_unexpected actual=%0h expected=none at %0t", m_data_o, $time);
        end else begin
          checkOutput("m_data", 64'(m_data_o), 64'(sb.pop_front()));
        end
        last_m_hs = cyc;
        m_count++;
      end
      hold_pending = m_valid_o && !m_ready_i;
      held_data    = m_data_o;
      if (proc_start_o && !prev_start) start_rise = cyc;
      if (err_o) begin
        err_count++;
        err_cyc = cyc;
      end
      if (!busy_o && prev_busy) busy_fall = cyc;
      prev_busy  = busy_o;
      prev_start = proc_start_o;
    end
  end

  // Stimulus words; tasks start and end 1 time unit after a rising edge.
  logic [31:0] st_a [DEPTH];
  logic [31:0] st_b [DEPTH];
  logic [31:0] st_opw [DEPTH];

  function automatic logic [31:0] wordOf(input int which, input int i);
    if (which == 0) return st_a[i];
    if (which == 1) return st_b[i];
    return st_opw[i];
  endfunction

  task automatic randomizeWords(input int n, input bit add_only);
    for (int i = 0; i < n; i++) begin
      st_a[i]   = $urandom;
      st_b[i]   = $urandom;
      st_opw[i] = add_only ? ($urandom & 32'hFFFF_FFF8) : $urandom;
    end
  endtask

  task automatic sendCmd(input int n);
    cmd_len_i   = LEN_WIDTH'(n);
    cmd_valid_i = 1'b1;
    @(negedge CLK);
    checkOutput("cmd_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge CLK); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic sendWords(input int n, input int which, input bit b2b);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      s_data_i  = wordOf(which, i);
      s_valid_i = 1'b1;
      @(negedge CLK);
      while (!s_ready_o && t < 100) begin @(negedge CLK); t++; end
      if (!s_ready_o) begin
        checkOutput("s_ready_wait", 64'(s_ready_o), 64'd1);
        s_valid_i = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      if (!b2b && $urandom_range(0, 2) == 0) begin
        s_valid_i = 1'b0;
        s_data_i  = $urandom;
        repeat ($urandom_range(1, 2)) @(posedge CLK);
        #1;
      end
    end
    s_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input bit b2b, input bit expect_results);
    if (expect_results)
      for (int i = 0; i < n; i++) sb.push_back(alu(st_a[i], st_b[i], st_opw[i][2:0]));
    sendCmd(n);
    sendWords(n, 0, b2b);
    sendWords(n, 1, b2b);
    sendWords(n, 2, b2b);
  endtask

  task automatic waitIdle(input int bound);
    int t = 0;
    @(negedge CLK);
    while (busy_o && t < bound) begin @(negedge CLK); t++; end
    checkOutput("idle_in_time", 64'(busy_o), 64'd0);
    @(posedge CLK); #1;
  endtask

  task automatic runAndCheck(input int n, input bit b2b);
    applyStimulus(n, b2b, 1'b1);
    waitIdle(n * 16 + 400);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("m_count", 64'(m_count), 64'(n));
    checkOutput("wr_cnt_a", 64'(wr_idx[0]), 64'(n));
    checkOutput("wr_cnt_b", 64'(wr_idx[1]), 64'(n));
    checkOutput("wr_cnt_op", 64'(wr_idx[2]), 64'(n));
    if (b2b) begin
      checkOutput("span_a", 64'(wr_last[0] - wr_first[0] + 1), 64'(n));
      checkOutput("span_b", 64'(wr_last[1] - wr_first[1] + 1), 64'(n));
      checkOutput("span_op", 64'(wr_last[2] - wr_first[2] + 1), 64'(n));
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int e0, s0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_s_ready", 64'(s_ready_o), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid_o), 64'd0);
    checkOutput("rst_m_data", 64'(m_data_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    checkOutput("rst_start", 64'(proc_start_o), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Directed ADD example.
    st_a[0] = 1;  st_a[1] = 2;  st_a[2] = 3;  st_a[3] = 4;
    st_b[0] = 10; st_b[1] = 20; st_b[2] = 30; st_b[3] = 40;
    for (int i = 0; i < 4; i++) st_opw[i] = 32'd0;
    runAndCheck(4, 1'b1);
    checkOutput("busy_fall_after_last", 64'(busy_fall - last_m_hs), 64'd1);

    // Full depth, back-to-back.
    randomizeWords(DEPTH, 1'b0);
    runAndCheck(DEPTH, 1'b1);

    // Slow consumer.
    rdy_mode = 1;
    randomizeWords(8, 1'b0);
    runAndCheck(8, 1'b0);
    rdy_mode = 0;

    // Illegal lengths.
    for (int j = 0; j < 2; j++) begin
      e0 = err_count;
      s0 = strobe_total;
      sendCmd(j == 0 ? 0 : 1025);
      repeat (4) @(posedge CLK);
      #1;
      checkOutput("illegal_err_once", 64'(err_count - e0), 64'd1);
      checkOutput("illegal_busy", 64'(busy_o), 64'd0);
      checkOutput("illegal_no_strobe", 64'(strobe_total - s0), 64'd0);
    end

    // Processor never finishes.
    done_en = 1'b0;
    e0 = err_count;
    randomizeWords(2, 1'b0);
    applyStimulus(2, 1'b1, 1'b0);
    waitIdle(TIMEOUT + 200);
    checkOutput("timeout_delay", 64'(err_cyc - start_rise), 64'(TIMEOUT));
    checkOutput("timeout_err_once", 64'(err_count - e0), 64'd1);
    checkOutput("timeout_start_low", 64'(proc_start_o), 64'd0);
    checkOutput("timeout_no_results", 64'(m_count), 64'd0);
    done_en = 1'b1;

    // Reset in the middle of LOAD_B.
    randomizeWords(6, 1'b0);
    sendCmd(6);
    sendWords(6, 0, 1'b1);
    sendWords(3, 1, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy_o), 64'd0);
    checkOutput("midrst_s_ready", 64'(s_ready_o), 64'd0);
    checkOutput("midrst_strobes", 64'({proc_ena_a_o, proc_wea_a_o, proc_ena_b_o, proc_wea_b_o,
                                       proc_ena_op_o, proc_wea_op_o, proc_ena_res_o, proc_start_o}), 64'd0);
    checkOutput("midrst_m_valid", 64'(m_valid_o), 64'd0);
    checkOutput("midrst_err", 64'(err_o), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("midrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge CLK); #1;
    randomizeWords(2, 1'b1);
    runAndCheck(2, 1'b0);

    // Randomised lengths, gaps and consumer back-pressure.
    for (int r = 0; r < 4; r++) begin
      rdy_mode = 2;
      randomizeWords(DEPTH, 1'b0);
      runAndCheck($urandom_range(1, 24), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
